// File: rtl/i2c_write_sequencer_if.sv
// Host, payload-stream and bit-engine signals of the I2C write sequencer.
// master: the sequencer itself; slave: the surrounding host plus bit engine.
interface i2c_write_sequencer_if #(
    parameter int LEN_W = 8
);
    logic             req_vld;
    logic             req_ready;
    logic [6:0]       req_addr;
    logic [LEN_W-1:0] req_len;
    logic             abort;
    logic [7:0]       wr_data;
    logic             wr_vld;
    logic             wr_ready;
    logic [2:0]       cmd;
    logic             cmd_vld;
    logic             cmd_ready;
    logic             sda_i;
    logic             busy;
    logic             done;
    logic             nack;
    logic [LEN_W-1:0] sent_cnt;

    modport master (
        input  req_vld, req_addr, req_len, abort, wr_data, wr_vld, cmd_ready, sda_i,
        output req_ready, wr_ready, cmd, cmd_vld, busy, done, nack, sent_cnt
    );

    modport slave (
        output req_vld, req_addr, req_len, abort, wr_data, wr_vld, cmd_ready, sda_i,
        input  req_ready, wr_ready, cmd, cmd_vld, busy, done, nack, sent_cnt
    );
endinterface

// File: rtl/i2c_write_sequencer.sv
// Expands one I2C write transaction into START / address / data / ACK / STOP bit-engine commands.
// Define I2C_ACK_CHECK_EN to sample SDA in each ACK slot and stop on NACK.
module i2c_write_sequencer #(
    parameter int LEN_W = 8
) (
    input logic                   clock,
    input logic                   rst_n,
    i2c_write_sequencer_if.master bus
);
    localparam logic [2:0] CMD_START = 3'd1;
    localparam logic [2:0] CMD_ONE   = 3'd2;
    localparam logic [2:0] CMD_ZERO  = 3'd3;
    localparam logic [2:0] CMD_STOP  = 3'd4;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, AACK, FETCH, DATA, DACK, STOP, DONE
    } state_t;

    state_t           state, state_n;
    logic [6:0]       addr_q;
    logic [LEN_W-1:0] len_q;
    logic [7:0]       shift_q;
    logic [2:0]       bit_cnt;
    logic             issued;
    logic             in_flight;
    logic             abort_pend;

    logic             xfer, complete, abort_now, ack_bad, present;
    logic             cmd_state, accept, take, load_addr, bit_step, cnt_inc, set_nack;
    logic [2:0]       cmd_code;
    logic [LEN_W:0]   cnt_next;

    // A bit is finished once the engine has dropped cmd_ready after the transfer and raised it again.
    assign xfer      = bus.cmd_vld && bus.cmd_ready;
    assign complete  = in_flight && !issued && bus.cmd_ready;
    assign abort_now = abort_pend || (bus.abort && state != IDLE);
    assign cnt_next  = {1'b0, bus.sent_cnt} + {{LEN_W{1'b0}}, 1'b1};
    assign present   = cmd_state && !bus.cmd_vld && !in_flight;

`ifdef I2C_ACK_CHECK_EN
    assign ack_bad = bus.sda_i;
`else
    logic unused_sda;
    assign unused_sda = bus.sda_i;
    assign ack_bad    = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        take      = 1'b0;
        load_addr = 1'b0;
        bit_step  = 1'b0;
        cnt_inc   = 1'b0;
        set_nack  = 1'b0;
        cmd_state = 1'b0;
        cmd_code  = CMD_ONE;
        case (state)
            IDLE: begin
                if (bus.req_vld) begin
                    accept  = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                cmd_state = 1'b1;
                cmd_code  = CMD_START;
                if (complete) begin
                    if (abort_now) begin
                        state_n = STOP;
                    end else begin
                        load_addr = 1'b1;
                        state_n   = ADDR;
                    end
                end
            end
            ADDR, DATA: begin
                cmd_state = 1'b1;
                cmd_code  = shift_q[7] ? CMD_ONE : CMD_ZERO;
                if (complete) begin
                    bit_step = 1'b1;
                    if (abort_now) begin
                        state_n = STOP;
                    end else if (bit_cnt == 3'd7) begin
                        state_n = (state == ADDR) ? AACK : DACK;
                    end
                end
            end
            AACK: begin
                cmd_state = 1'b1;
                if (complete) begin
                    if (ack_bad) begin
                        set_nack = 1'b1;
                        state_n  = STOP;
                    end else if (abort_now || len_q == '0) begin
                        state_n = STOP;
                    end else begin
                        state_n = FETCH;
                    end
                end
            end
            FETCH: begin
                if (abort_now) begin
                    state_n = STOP;
                end else if (bus.wr_vld) begin
                    take    = 1'b1;
                    state_n = DATA;
                end
            end
            DACK: begin
                cmd_state = 1'b1;
                if (complete) begin
                    if (ack_bad) begin
                        set_nack = 1'b1;
                        state_n  = STOP;
                    end else begin
                        cnt_inc = 1'b1;
                        if (!abort_now && cnt_next < {1'b0, len_q}) state_n = FETCH;
                        else                                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                cmd_state = 1'b1;
                cmd_code  = CMD_STOP;
                if (complete) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
            bus.wr_ready  <= 1'b0;
            bus.cmd       <= '0;
            bus.cmd_vld   <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.nack      <= 1'b0;
            bus.sent_cnt  <= '0;
            addr_q        <= '0;
            len_q         <= '0;
            shift_q       <= '0;
            bit_cnt       <= '0;
            issued        <= 1'b0;
            in_flight     <= 1'b0;
            abort_pend    <= 1'b0;
        end else begin
            state         <= state_n;
            bus.req_ready <= (state_n == IDLE);
            bus.busy      <= (state_n != IDLE) && (state_n != DONE);
            bus.done      <= (state_n == DONE);
            bus.wr_ready  <= take;

            if (accept) begin
                addr_q       <= bus.req_addr;
                len_q        <= bus.req_len;
                bus.sent_cnt <= '0;
                bus.nack     <= 1'b0;
            end else if (set_nack) begin
                bus.nack <= 1'b1;
            end
            if (cnt_inc) bus.sent_cnt <= cnt_next[LEN_W-1:0];

            if (accept || state == DONE) abort_pend <= 1'b0;
            else if (abort_now)          abort_pend <= 1'b1;

            if (xfer) begin
                bus.cmd_vld <= 1'b0;
                issued      <= 1'b1;
                in_flight   <= 1'b1;
            end else begin
                if (present) begin
                    bus.cmd_vld <= 1'b1;
                    bus.cmd     <= cmd_code;
                end
                if (issued && !bus.cmd_ready) issued <= 1'b0;
                if (complete) in_flight <= 1'b0;
            end

            // Bits leave MSB first; the counter marks the eighth bit of the byte.
            if (load_addr) begin
                shift_q <= {addr_q, 1'b0};
                bit_cnt <= '0;
            end else if (take) begin
                shift_q <= bus.wr_data;
                bit_cnt <= '0;
            end else if (bit_step) begin
                shift_q <= {shift_q[6:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Directed bench for i2c_write_sequencer driving a bit-engine model that is busy 4 cycles per command.
module tb_i2c_write_sequencer;
    localparam int          LEN_W      = 8;
    localparam logic [31:0] RESET_OUTS = 32'h0001_0000;

    logic clock = 1'b0;
    logic rst_n = 1'b0;

    i2c_write_sequencer_if #(.LEN_W(LEN_W)) bus();

    i2c_write_sequencer #(.LEN_W(LEN_W)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    logic       eng_ready;
    int         eng_cnt;
    logic [2:0] log_mem [0:255];
    int         n_log  = 0;
    int         n_wr   = 0;
    int         n_done = 0;
    int         n_assert = 0;
    int         n_fail   = 0;
    logic [2:0] exp_q [$];

    assign bus.cmd_ready = eng_ready;

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            eng_ready <= 1'b1;
            eng_cnt   <= 0;
        end else if (eng_ready) begin
            if (bus.cmd_vld) begin
                eng_ready <= 1'b0;
                eng_cnt   <= 3;
            end
        end else if (eng_cnt == 0) begin
            eng_ready <= 1'b1;
        end else begin
            eng_cnt <= eng_cnt - 1;
        end
    end

    always @(posedge clock) begin
        if (rst_n && bus.cmd_vld && eng_ready) begin
            log_mem[n_log % 256] <= bus.cmd;
            n_log <= n_log + 1;
        end
        if (bus.wr_ready) n_wr <= n_wr + 1;
        if (bus.done) n_done <= n_done + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack_outs();
        return 32'({bus.req_ready, bus.wr_ready, bus.cmd, bus.cmd_vld,
                    bus.busy, bus.done, bus.nack, bus.sent_cnt});
    endfunction

    task automatic push_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v[7-i] ? 3'd2 : 3'd3);
    endtask

    task automatic push_byte(input logic [7:0] v);
        push_bits(v, 8);
        exp_q.push_back(3'd2);
    endtask

    task automatic compare_log(input string tag, input int base);
        chk({tag, "_ncmd"}, 32'(n_log - base), 32'(exp_q.size()));
        foreach (exp_q[i])
            chk($sformatf("%s_cmd%0d", tag, i), 32'(log_mem[(base + i) % 256]), 32'(exp_q[i]));
    endtask

    task automatic request(input logic [6:0] a, input logic [7:0] n);
        int k = 0;
        while (!bus.req_ready && k < 100) begin
            @(negedge clock);
            k++;
        end
        chk("req_ready_wait", 32'(bus.req_ready), 32'h1);
        bus.req_addr = a;
        bus.req_len  = n;
        bus.req_vld  = 1'b1;
        @(negedge clock);
        bus.req_vld  = 1'b0;
    endtask

    task automatic wait_wr(input string tag);
        int k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!bus.wr_ready && k < 3000);
        chk({tag, "_wr_ready_wait"}, 32'(bus.wr_ready), 32'h1);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!bus.done && k < 3000);
        chk({tag, "_done_wait"}, 32'(bus.done), 32'h1);
    endtask

    task automatic wait_log(input string tag, input int n);
        int k = 0;
        while (n_log < n && k < 3000) begin
            @(negedge clock);
            k++;
        end
        chk({tag, "_log_wait"}, 32'(n_log >= n), 32'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, wb, db, viol, nb, k;
        bus.req_vld  = 1'b0;
        bus.req_addr = '0;
        bus.req_len  = '0;
        bus.abort    = 1'b0;
        bus.wr_data  = '0;
        bus.wr_vld   = 1'b0;
        bus.sda_i    = 1'b0;

        repeat (3) @(negedge clock);
        chk("reset_outputs", pack_outs(), RESET_OUTS);
        rst_n = 1'b1;
        @(negedge clock);
        chk("idle_after_release", pack_outs(), RESET_OUTS);

        // Address only
        base = n_log; wb = n_wr; db = n_done;
        request(7'h50, 8'd0);
        chk("t1_busy", 32'({bus.busy, bus.req_ready}), 32'h2);
        wait_done("t1");
        chk("t1_sent", 32'(bus.sent_cnt), 32'h0);
        repeat (3) @(negedge clock);
        chk("t1_done_cnt", 32'(n_done - db), 32'h1);
        chk("t1_wr_cnt", 32'(n_wr - wb), 32'h0);
        chk("t1_idle", 32'({bus.busy, bus.req_ready}), 32'h1);
        chk("t1_total", 32'(n_log - base), 32'd11);
        exp_q.delete();
        exp_q.push_back(3'd1);
        push_byte({7'h50, 1'b0});
        exp_q.push_back(3'd4);
        compare_log("t1", base);

        // Two bytes
        base = n_log; wb = n_wr; db = n_done;
        bus.wr_data = 8'hA5;
        bus.wr_vld  = 1'b1;
        request(7'h3C, 8'd2);
        wait_wr("t2_b0");
        bus.wr_data = 8'h0F;
        @(negedge clock);
        chk("t2_wr_pulse_width", 32'(bus.wr_ready), 32'h0);
        wait_wr("t2_b1");
        bus.wr_vld = 1'b0;
        wait_done("t2");
        chk("t2_sent", 32'(bus.sent_cnt), 32'h2);
        repeat (3) @(negedge clock);
        chk("t2_wr_cnt", 32'(n_wr - wb), 32'h2);
        chk("t2_done_cnt", 32'(n_done - db), 32'h1);
        chk("t2_total", 32'(n_log - base), 32'd29);
        exp_q.delete();
        exp_q.push_back(3'd1);
        push_byte({7'h3C, 1'b0});
        push_byte(8'hA5);
        push_byte(8'h0F);
        exp_q.push_back(3'd4);
        compare_log("t2", base);

        // Stalled payload stream
        base = n_log; wb = n_wr; db = n_done;
        request(7'h12, 8'd1);
        wait_log("t3_aack", base + 10);
        k = 0;
        while (!bus.cmd_ready && k < 100) begin
            @(negedge clock);
            k++;
        end
        chk("t3_engine_idle", 32'(bus.cmd_ready), 32'h1);
        viol = 0;
        nb   = n_log;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (bus.cmd_vld || !bus.cmd_ready) viol++;
        end
        chk("t3_stall_quiet", 32'(viol), 32'h0);
        chk("t3_stall_nocmd", 32'(n_log - nb), 32'h0);
        chk("t3_stall_busy", 32'(bus.busy), 32'h1);
        bus.wr_data = 8'hC3;
        bus.wr_vld  = 1'b1;
        wait_wr("t3");
        bus.wr_vld = 1'b0;
        wait_done("t3");
        chk("t3_sent", 32'(bus.sent_cnt), 32'h1);
        exp_q.delete();
        exp_q.push_back(3'd1);
        push_byte({7'h12, 1'b0});
        push_byte(8'hC3);
        exp_q.push_back(3'd4);
        compare_log("t3", base);

        // Abort during the third bit of byte 0
        repeat (3) @(negedge clock);
        base = n_log; wb = n_wr; db = n_done;
        bus.wr_data = 8'h81;
        bus.wr_vld  = 1'b1;
        request(7'h21, 8'd3);
        wait_wr("t4");
        bus.wr_data = 8'h7E;
        wait_log("t4_bit3", base + 13);
        bus.abort = 1'b1;
        @(negedge clock);
        bus.abort = 1'b0;
        wait_done("t4");
        bus.wr_vld = 1'b0;
        chk("t4_sent", 32'(bus.sent_cnt), 32'h0);
        repeat (3) @(negedge clock);
        chk("t4_wr_cnt", 32'(n_wr - wb), 32'h1);
        chk("t4_done_cnt", 32'(n_done - db), 32'h1);
        exp_q.delete();
        exp_q.push_back(3'd1);
        push_byte({7'h21, 1'b0});
        push_bits(8'h81, 3);
        exp_q.push_back(3'd4);
        compare_log("t4", base);

        // Reset mid-DATA, then a clean transaction
        base = n_log;
        bus.wr_data = 8'h55;
        bus.wr_vld  = 1'b1;
        request(7'h44, 8'd2);
        wait_log("t5_mid", base + 12);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_reset", pack_outs(), RESET_OUTS);
        bus.wr_vld = 1'b0;
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        chk("t5_after_release", pack_outs(), RESET_OUTS);
        base = n_log; wb = n_wr; db = n_done;
        bus.wr_data = 8'h3C;
        bus.wr_vld  = 1'b1;
        request(7'h0A, 8'd1);
        wait_wr("t5");
        bus.wr_vld = 1'b0;
        wait_done("t5");
        chk("t5_sent", 32'(bus.sent_cnt), 32'h1);
        repeat (3) @(negedge clock);
        chk("t5_done_cnt", 32'(n_done - db), 32'h1);
        exp_q.delete();
        exp_q.push_back(3'd1);
        push_byte({7'h0A, 1'b0});
        push_byte(8'h3C);
        exp_q.push_back(3'd4);
        compare_log("t5", base);

`ifdef I2C_ACK_CHECK_EN
        // NACK on byte 1 stops the transfer
        base = n_log; wb = n_wr; db = n_done;
        bus.wr_data = 8'h11;
        bus.wr_vld  = 1'b1;
        request(7'h33, 8'd3);
        wait_wr("t6_b0");
        bus.wr_data = 8'h22;
        wait_wr("t6_b1");
        bus.wr_data = 8'h33;
        wait_log("t6_ack1", base + 28);
        bus.sda_i = 1'b1;
        wait_done("t6");
        bus.sda_i  = 1'b0;
        bus.wr_vld = 1'b0;
        chk("t6_nack", 32'(bus.nack), 32'h1);
        chk("t6_sent", 32'(bus.sent_cnt), 32'h1);
        repeat (3) @(negedge clock);
        chk("t6_wr_cnt", 32'(n_wr - wb), 32'h2);
        exp_q.delete();
        exp_q.push_back(3'd1);
        push_byte({7'h33, 1'b0});
        push_byte(8'h11);
        push_byte(8'h22);
        exp_q.push_back(3'd4);
        compare_log("t6", base);
        request(7'h33, 8'd0);
        chk("t6_nack_cleared", 32'(bus.nack), 32'h0);
        wait_done("t6_next");
`else
        // ACK level is ignored: all bytes go out with SDA high
        base = n_log; wb = n_wr; db = n_done;
        bus.sda_i   = 1'b1;
        bus.wr_data = 8'h11;
        bus.wr_vld  = 1'b1;
        request(7'h33, 8'd2);
        wait_wr("t6_b0");
        bus.wr_data = 8'h22;
        wait_wr("t6_b1");
        bus.wr_vld = 1'b0;
        wait_done("t6");
        bus.sda_i = 1'b0;
        chk("t6_nack", 32'(bus.nack), 32'h0);
        chk("t6_sent", 32'(bus.sent_cnt), 32'h2);
        repeat (3) @(negedge clock);
        chk("t6_wr_cnt", 32'(n_wr - wb), 32'h2);
        exp_q.delete();
        exp_q.push_back(3'd1);
        push_byte({7'h33, 1'b0});
        push_byte(8'h11);
        push_byte(8'h22);
        exp_q.push_back(3'd4);
        compare_log("t6", base);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
